// File: rtl/fwnoc_ni_tx_if.sv
// Host-side bundle of the fwnoc transmit NI: command, payload stream and router-facing flit port.
// master is the host/router environment, slave is the NI itself.
interface fwnoc_ni_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            cmd_dst_x;
    logic [3:0]            cmd_dst_y;
    logic [7:0]            cmd_len;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] pl_data;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output cmd_dst_x, cmd_dst_y, cmd_len, cmd_valid,
        input  cmd_ready,
        output pl_data, pl_valid,
        input  pl_ready,
        input  out_data, out_valid,
        output out_ready
    );

    modport slave (
        input  cmd_dst_x, cmd_dst_y, cmd_len, cmd_valid,
        output cmd_ready,
        input  pl_data, pl_valid,
        output pl_ready,
        output out_data, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/fwnoc_ni_tx.sv
// Transmit network interface: packs a (dst, len) command and len payload words into one
// fwnoc packet (header flit + payload flits) behind a single-register output stage.
module fwnoc_ni_tx #(
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    fwnoc_ni_tx_if.slave        bus,
    output logic                busy,
    output logic [15:0]         pkt_count
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_valid_reg;
    logic                  last_reg;
    logic [7:0]            remaining_reg;
    logic [15:0]           pkt_count_reg;

    logic                  load_ok;
    logic                  load_hdr;
    logic                  load_pl;
    logic                  cmd_ready_next;
    logic                  pl_ready_next;
    logic                  drain;
    logic [DATA_WIDTH-1:0] header;

    // Header occupies the low 32 bits; any wider flit is zero-extended.
    assign header[31:0] = {bus.cmd_dst_x, bus.cmd_dst_y, 4'(X_ID), 4'(Y_ID), 8'h00, bus.cmd_len};
    generate
        for (genvar gi = 32; gi < DATA_WIDTH; gi++) begin : g_hdr_pad
            assign header[gi] = 1'b0;
        end
    endgenerate

    // The output register can take a new flit when it is empty or draining this cycle.
    assign load_ok = !out_valid_reg || bus.out_ready;
    assign drain   = out_valid_reg && bus.out_ready;

    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = 1'b0;
        pl_ready_next  = 1'b0;
        load_hdr       = 1'b0;
        load_pl        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready_next = load_ok;
                if (bus.cmd_valid && load_ok) begin
                    load_hdr = 1'b1;
                    if (bus.cmd_len != 8'd0) begin
                        state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                pl_ready_next = load_ok;
                if (bus.pl_valid && load_ok) begin
                    load_pl = 1'b1;
                    if (remaining_reg == 8'd1) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            last_reg      <= 1'b0;
            remaining_reg <= 8'd0;
            pkt_count_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (load_hdr) begin
                out_data_reg  <= header;
                out_valid_reg <= 1'b1;
                last_reg      <= (bus.cmd_len == 8'd0);
                remaining_reg <= bus.cmd_len;
            end else if (load_pl) begin
                out_data_reg  <= bus.pl_data;
                out_valid_reg <= 1'b1;
                last_reg      <= (remaining_reg == 8'd1);
                remaining_reg <= remaining_reg - 8'd1;
            end else if (drain) begin
                out_valid_reg <= 1'b0;
            end
            if (drain && last_reg) begin
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_next;
    assign bus.pl_ready  = pl_ready_next;
    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign busy          = (state_reg != ST_IDLE) || out_valid_reg;
    assign pkt_count     = pkt_count_reg;

endmodule

// File: tb/tb_fwnoc_ni_tx.sv
// Randomized scoreboard bench for fwnoc_ni_tx: packets are expanded into expected flit
// sequences when issued; an independent monitor compares every flit the NI delivers.
module tb_fwnoc_ni_tx;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } flit_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [15:0] pkt_count;

    fwnoc_ni_tx_if #(.DATA_WIDTH(DW)) bus ();

    fwnoc_ni_tx #(.X_ID(7), .Y_ID(5), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clock = ~clock;

    flit_t       exp_q[$];
    logic [31:0] pl_q[$];
    int          flit_cycles[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_pkt  = 16'd0;
    int          pending  = 0;
    bit          mon_en   = 1'b0;
    bit          verbose  = 1'b1;
    int          cycle    = 0;
    int          or_rate  = 100;
    int          pl_rate  = 100;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'd0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Router side: out_ready toggled randomly at the configured acceptance rate.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            bus.out_ready = ($urandom_range(99) < or_rate);
        end
    end

    // Payload source: offers the head of pl_q, pops it once the handshake is certain.
    initial begin
        bus.pl_valid = 1'b0;
        bus.pl_data  = '0;
        forever begin
            @(posedge clock); #1;
            if (pl_q.size() > 0 && $urandom_range(99) < pl_rate) begin
                bus.pl_valid = 1'b1;
                bus.pl_data  = pl_q[0];
            end else begin
                bus.pl_valid = 1'b0;
                bus.pl_data  = $urandom;
            end
            @(negedge clock);
            if (bus.pl_valid && bus.pl_ready && pl_q.size() > 0) void'(pl_q.pop_front());
        end
    end

    // Monitor: protocol rules from the model's packet bookkeeping, plus flit scoreboard.
    initial begin
        flit_t f;
        logic  ld_ok;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                ld_ok = !bus.out_valid || bus.out_ready;
                check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
                check("cmd_ready", 32'(bus.cmd_ready), 32'((pending == 0) && ld_ok));
                check("pl_ready",  32'(bus.pl_ready),  32'((pending > 0) && ld_ok));
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data",  bus.out_data, prev_data);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_flit: got %h, required no flit", bus.out_data);
                    end else begin
                        f = exp_q.pop_front();
                        check("flit", bus.out_data, f.data);
                        if (f.last) exp_pkt = exp_pkt + 16'd1;
                        flit_cycles.push_back(cycle);
                        if (verbose)
                            $display("flit @%0d data=%h expected=%h last=%0d", cycle, bus.out_data, f.data, f.last);
                    end
                end
                if (bus.cmd_valid && bus.cmd_ready) pending += int'(bus.cmd_len);
                if (bus.pl_valid && bus.pl_ready) pending--;
            end
        end
    end

    // Expands one packet into expected flits and payload words, then issues the command.
    // Called and returns at posedge+1.
    task automatic queue_pkt(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len,
                             input bit seq_words);
        flit_t       f;
        logic [31:0] w;
        bit          ok;
        f.data = {x, y, 4'd7, 4'd5, 8'h00, len};
        f.last = (len == 8'd0);
        exp_q.push_back(f);
        for (int i = 0; i < int'(len); i++) begin
            w = seq_words ? 32'hA + 32'(i) : $urandom;
            pl_q.push_back(w);
            f.data = w;
            f.last = (i == int'(len) - 1);
            exp_q.push_back(f);
        end
        bus.cmd_dst_x = x;
        bus.cmd_dst_y = y;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge clock);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL cmd_accept: got no cmd_ready, required acceptance within 20000 cycles");
        end
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        if (verbose) $display("cmd issued x=%0d y=%0d len=%0d", x, y, len);
    endtask

    task automatic wait_drain(input int limit);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < limit; t++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && pl_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL drain: got %0d flits outstanding, required 0", exp_q.size());
        @(posedge clock); #1;
    endtask

    task automatic wait_flits(input int n);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clock);
            if (flit_cycles.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL flit_wait: got %0d flits, required %0d", flit_cycles.size(), n);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] len;
        int         r;
        int         gaps;
        bus.cmd_dst_x = '0;
        bus.cmd_dst_y = '0;
        bus.cmd_len   = '0;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  bus.out_data, 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        @(posedge clock); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Fixed payload 0xA, 0xB: header 0x23750002 then two payload flits back-to-back.
        flit_cycles.delete();
        queue_pkt(4'd2, 4'd3, 8'd2, 1'b1);
        wait_drain(200);
        check("t1_flits", 32'(flit_cycles.size()), 32'd3);
        check("t1_span",  32'(flit_cycles[$] - flit_cycles[0]), 32'd2);
        check("t1_pkts",  32'(pkt_count), 32'd1);

        // Zero-length packet: header only.
        queue_pkt(4'd4, 4'd1, 8'd0, 1'b0);
        wait_drain(200);
        check("t2_pkts", 32'(pkt_count), 32'd2);

        // Stall mid-payload for several cycles.
        flit_cycles.delete();
        queue_pkt(4'd1, 4'd1, 8'd4, 1'b0);
        wait_flits(2);
        or_rate = 0;
        repeat (5) @(posedge clock);
        or_rate = 100;
        wait_drain(500);

        // Two packets queued back-to-back: 6 flits in 6 consecutive cycles.
        flit_cycles.delete();
        queue_pkt(4'd3, 4'd6, 8'd3, 1'b0);
        queue_pkt(4'd8, 4'd9, 8'd1, 1'b0);
        wait_drain(200);
        check("t4_flits", 32'(flit_cycles.size()), 32'd6);
        check("t4_span",  32'(flit_cycles[$] - flit_cycles[0]), 32'd5);

        // Random traffic with router back-pressure and payload gaps.
        or_rate = 70;
        pl_rate = 70;
        for (int p = 0; p < 150; p++) begin
            r = int'($urandom_range(99));
            if (r < 10)      len = 8'd0;
            else if (r < 12) len = 8'd255;
            else             len = 8'($urandom_range(12, 1));
            gaps = int'($urandom_range(2));
            repeat (gaps) begin
                @(posedge clock); #1;
            end
            queue_pkt(4'($urandom), 4'($urandom), len, 1'b0);
        end
        wait_drain(20000);
        or_rate = 100;
        pl_rate = 100;

        // Reset after header plus one payload flit of a len=4 packet.
        flit_cycles.delete();
        queue_pkt(4'd5, 4'd5, 8'd4, 1'b0);
        wait_flits(2);
        @(posedge clock); #2;
        reset  = 1'b1;
        mon_en = 1'b0;
        @(posedge clock); #2;
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_busy",      32'(busy), 32'd0);
        check("t5_pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        pl_q.delete();
        pending    = 0;
        exp_pkt    = 16'd0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        @(posedge clock); #1;
        queue_pkt(4'd9, 4'd4, 8'd0, 1'b0);
        wait_drain(200);
        check("t5_clean_pkt", 32'(pkt_count), 32'd1);

        // 65535 more zero-length packets bring the counter to 65536 -> wraps to 0.
        verbose = 1'b0;
        for (int p = 0; p < 65535; p++) begin
            queue_pkt(4'($urandom), 4'($urandom), 8'd0, 1'b0);
        end
        wait_drain(200);
        verbose = 1'b1;
        check("t6_wrap", 32'(pkt_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
